// File: rtl/mult_issue_ctrl_if.sv
// Handshake/bus bundle between the decode front end, mult_issue_ctrl and the execute stage.
interface mult_issue_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              instr_valid;
  logic [5:0]        ALU_ctr;
  logic [REG_AW-1:0] rd_in;
  logic              mult_done;
  logic [31:0]       exec_out;
  logic              doMult;
  logic              stall;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic              busy;
  logic              mult_err;

  modport slave (
    input  instr_valid, ALU_ctr, rd_in, mult_done, exec_out,
    output doMult, stall, wb_en, wb_addr, wb_data, busy, mult_err
  );

  modport master (
    output instr_valid, ALU_ctr, rd_in, mult_done, exec_out,
    input  doMult, stall, wb_en, wb_addr, wb_data, busy, mult_err
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Multiply issue sequencer: pulses doMult, stalls the front end until mult_done, then writes back once.
// Optional WAIT timeout with sticky mult_err is enabled by defining MULT_TIMEOUT_EN.
module mult_issue_ctrl #(
  parameter logic [5:0]  OPC_MULT  = 6'h0e,
  parameter logic [5:0]  OPC_MULTU = 6'h16,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic              clk,
  input logic              reset,
  mult_issue_ctrl_if.slave bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mult_issue_ctrl: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [REG_AW-1:0] r_wb_addr;
  logic [31:0]       r_wb_data;
  logic              w_is_mult;
  logic              w_capture;

  assign w_is_mult = bus.instr_valid &
                     ((bus.ALU_ctr == OPC_MULT) | (bus.ALU_ctr == OPC_MULTU));

`ifdef MULT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic w_timeout;
  logic r_err;
`endif

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
`ifdef MULT_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      S_IDLE:  if (w_is_mult) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        // A done coinciding with the timeout cycle takes priority
        if (bus.mult_done) begin
          w_capture = 1'b1;
          w_next    = S_WRITE;
        end
`ifdef MULT_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_WRITE;
        end
`endif
      end
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_is_mult) r_wb_addr <= bus.rd_in;
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && r_cnt != '1) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) r_wb_data <= bus.exec_out;
`ifdef MULT_TIMEOUT_EN
      else if (w_timeout) r_wb_data <= '0;
`endif
    end
  end

`ifdef MULT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end
  assign bus.mult_err = r_err;
`else
  assign bus.mult_err = 1'b0;
`endif

  // Gating with reset keeps stall low while reset is held, even with a multiply on the inputs
  assign bus.stall   = reset & (((r_state == S_IDLE) & w_is_mult) |
                                (r_state == S_START) | (r_state == S_WAIT));
  assign bus.doMult  = (r_state == S_START);
  assign bus.wb_en   = (r_state == S_WRITE);
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomized and directed bench for mult_issue_ctrl against a timestamp-based operation model.
module tb_mult_issue_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 8;
`ifdef MULT_TIMEOUT_EN
  localparam int unsigned NW = 5;
`else
  localparam int unsigned NW = 32;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_issue_ctrl_if #(.REG_AW(AW)) bus ();

  mult_issue_ctrl #(
    .OPC_MULT (6'h0e),
    .OPC_MULTU(6'h16),
    .REG_AW   (AW),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mult_f(input logic v, input logic [5:0] op);
    return (v === 1'b1) && (op == 6'h0e || op == 6'h16);
  endfunction

  // Model: an operation is identified by the clock edge it was issued on; phases follow from its age.
  bit          m_active = 0;
  bit          m_wbph = 0;
  bit          m_err = 0;
  int          m_cyc = 0;
  int          m_issue = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_data = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_active = 0; m_wbph = 0; m_err = 0; m_addr = '0; m_data = '0;
    end else begin
      if (!m_active) begin
        if (is_mult_f(bus.instr_valid, bus.ALU_ctr)) begin
          m_active = 1; m_wbph = 0; m_issue = m_cyc + 1; m_addr = bus.rd_in;
        end
      end else if (m_wbph) begin
        m_active = 0; m_wbph = 0;
      end else if (m_cyc - m_issue >= 1) begin
        if (bus.mult_done) begin
          m_data = bus.exec_out; m_wbph = 1;
        end
`ifdef MULT_TIMEOUT_EN
        else if (m_cyc - m_issue == int'(TO)) begin
          m_data = '0; m_err = 1; m_wbph = 1;
        end
`endif
      end
      m_cyc++;
    end
  end

  bit chk_on = 0;
  int n_do = 0, n_wb = 0, n_stall = 0;
  logic [AW-1:0] wbq[$];

  initial forever begin
    @(negedge clk);
    if (reset && chk_on) begin
      chk("stall",   bus.stall,  (!m_active && is_mult_f(bus.instr_valid, bus.ALU_ctr)) ||
                                 (m_active && !m_wbph));
      chk("doMult",  bus.doMult, m_active && (m_cyc == m_issue));
      chk("wb_en",   bus.wb_en,  m_active && m_wbph);
      chk("busy",    bus.busy,   m_active);
      chk("wb_addr", bus.wb_addr, m_addr);
      chk("wb_data", bus.wb_data, m_data);
`ifdef MULT_TIMEOUT_EN
      chk("mult_err", bus.mult_err, m_err);
`else
      chk("mult_err", bus.mult_err, 1'b0);
`endif
      if (bus.doMult) n_do++;
      if (bus.stall)  n_stall++;
      if (bus.wb_en) begin n_wb++; wbq.push_back(bus.wb_addr); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic idle_in();
    bus.instr_valid = 1'b0; bus.ALU_ctr = '0; bus.rd_in = '0;
    bus.mult_done = 1'b0; bus.exec_out = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_doMult"},  bus.doMult, 0);
    chk({tag, "_stall"},   bus.stall, 0);
    chk({tag, "_wb_en"},   bus.wb_en, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_wb_addr"}, bus.wb_addr, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_err"},     bus.mult_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, s0, w0, q0;
    idle_in();
    #12 chk_all_zero("reset");
    reset = 1'b1;
    chk_on = 1;
    tick();

    // Non-multiply traffic is never stalled
    d0 = n_do; s0 = n_stall; w0 = n_wb;
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h00; bus.rd_in = 5'd1;
    repeat (10) tick();
    chk("nonmult_doMult", n_do - d0, 0);
    chk("nonmult_stall",  n_stall - s0, 0);
    chk("nonmult_wb",     n_wb - w0, 0);
    idle_in(); tick();

    // Signed multiply, done after NW WAIT cycles
    d0 = n_do; s0 = n_stall; w0 = n_wb;
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h0e; bus.rd_in = 5'd9;
    tick();
    bus.instr_valid = 1'b0;
    repeat (NW) tick();
    bus.mult_done = 1'b1; bus.exec_out = 32'hFFFF_FFFA;
    tick();
    bus.mult_done = 1'b0; bus.exec_out = 32'h1234_5678;
    at_neg();
    chk("smul_wb_en",   bus.wb_en, 1);
    chk("smul_wb_addr", bus.wb_addr, 9);
    chk("smul_wb_data", bus.wb_data, 32'hFFFF_FFFA);
    chk("smul_model_data", m_data, 32'hFFFF_FFFA);
    chk("smul_doMult_cnt", n_do - d0, 1);
    chk("smul_stall_cnt",  n_stall - s0, NW + 2);
    tick();
    chk("smul_wb_cnt", n_wb - w0, 1);

    // Unsigned multiply with done held from the issue cycle
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h16; bus.rd_in = 5'd21;
    bus.mult_done = 1'b1; bus.exec_out = 32'h0001_0000;
    tick();
    bus.instr_valid = 1'b0;
    at_neg();
    chk("umul_start_doMult", bus.doMult, 1);
    chk("umul_start_wb_en",  bus.wb_en, 0);
    tick(); at_neg();
    chk("umul_wait_wb_en", bus.wb_en, 0);
    tick(); at_neg();
    chk("umul_wb_en",   bus.wb_en, 1);
    chk("umul_wb_data", bus.wb_data, 32'h0001_0000);
    chk("umul_wb_addr", bus.wb_addr, 21);
    tick();
    idle_in(); tick();

    // Back-to-back: second multiply arrives during WRITE of the first
    d0 = n_do; q0 = wbq.size();
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h0e; bus.rd_in = 5'd7;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    bus.mult_done = 1'b1; bus.exec_out = $urandom;
    tick();
    bus.mult_done = 1'b0;
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h16; bus.rd_in = 5'd3;
    tick();
    tick();
    bus.instr_valid = 1'b0;
    tick();
    bus.mult_done = 1'b1; bus.exec_out = $urandom;
    tick();
    bus.mult_done = 1'b0;
    tick();
    chk("b2b_wb_cnt",  wbq.size() - q0, 2);
    if (wbq.size() >= q0 + 2) begin
      chk("b2b_addr0", wbq[q0], 7);
      chk("b2b_addr1", wbq[q0+1], 3);
    end
    chk("b2b_doMult_cnt", n_do - d0, 2);
    idle_in(); tick();

`ifdef MULT_TIMEOUT_EN
    // Timeout: no done for TO WAIT cycles
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h0e; bus.rd_in = 5'd12;
    tick();
    bus.instr_valid = 1'b0;
    repeat (TO) tick();
    at_neg();
    chk("to_early_wb_en", bus.wb_en, 0);
    tick(); at_neg();
    chk("to_wb_en",   bus.wb_en, 1);
    chk("to_wb_data", bus.wb_data, 0);
    chk("to_err",     bus.mult_err, 1);
    tick();
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h16; bus.rd_in = 5'd4;
    bus.mult_done = 1'b1; bus.exec_out = 32'h55;
    tick(); bus.instr_valid = 1'b0;
    tick(); tick(); at_neg();
    chk("to_ok_wb_data", bus.wb_data, 32'h55);
    chk("to_err_sticky", bus.mult_err, 1);
    tick();
    idle_in(); tick();
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom % 4;
      bus.instr_valid = 1'($urandom);
      bus.ALU_ctr     = (r == 0) ? 6'h0e : (r == 1) ? 6'h16 : 6'($urandom);
      bus.rd_in       = 5'($urandom);
      bus.mult_done   = ($urandom % 4 == 0);
      bus.exec_out    = $urandom;
      tick();
    end
    idle_in();
    repeat (4) tick();

    // Asynchronous reset mid-WAIT, with a multiply still on the inputs
    bus.instr_valid = 1'b1; bus.ALU_ctr = 6'h0e; bus.rd_in = 5'd30;
    tick();
    repeat (5) tick();
    #2 chk_on = 0; reset = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #3;
    idle_in();
    reset = 1'b1;
    chk_on = 1;
    w0 = n_wb;
    bus.mult_done = 1'b1; bus.exec_out = 32'hDEAD_BEEF;
    repeat (5) tick();
    chk("rst_stale_done_wb", n_wb - w0, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    idle_in(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Sequencer that sits directly upstream of the execute stage.
- Detects multiply instructions, issues a one-cycle doMult pulse, and stalls the front end until the execute stage reports mult_done.
- Captures the execute output and presents a one-cycle register-file writeback.
- Non-multiply instructions are not touched; they use the normal single-cycle path.

Parameters:
- OPC_MULT, 6'h0e: ALU_ctr encoding for signed multiply.
- OPC_MULTU, 6'h16: ALU_ctr encoding for unsigned multiply.
- REG_AW, 5: register destination address width.
- TIMEOUT, 64: maximum WAIT cycles before abort. Used only with MULT_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- instr_valid  in  1  decoded instruction present this cycle.
- ALU_ctr  in  6  ALU control of current instruction.
- rd_in  in  REG_AW  destination register of current instruction.
- mult_done  in  1  completion flag from execute stage.
- exec_out  in  32  execute-stage result bus.
- doMult  out  1  start pulse to execute stage.
- stall  out  1  freeze PC/decode.
- wb_en  out  1  register-file write strobe for the multiply result.
- wb_addr  out  REG_AW  writeback destination.
- wb_data  out  32  captured multiply result.
- busy  out  1  FSM not in IDLE.
- mult_err  out  1  sticky timeout flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; rd latch, data latch and counter 0.
- is_mult = instr_valid & (ALU_ctr==OPC_MULT | ALU_ctr==OPC_MULTU).
- States:
  - IDLE: if is_mult, latch rd_in into wb_addr and go to START; otherwise stay.
  - START: doMult=1 for exactly this cycle; clear counter; go to WAIT.
  - WAIT: counter increments each cycle, saturating at 255. When mult_done=1, register exec_out into wb_data and go to WRITE.
  - WRITE: wb_en=1 for exactly one cycle; go to IDLE.
- stall (combinational) = (IDLE & is_mult) | START | WAIT. stall is 0 in WRITE, so the front end resumes the cycle the writeback occurs.
- busy = state != IDLE.
- mult_done handling:
  - mult_done sampled in IDLE or START is ignored; a stale done from the previous operation cannot complete a new one.
  - The earliest accepted mult_done is in the first WAIT cycle.
- Latency: issue to wb_en is at least 3 cycles (IDLE→START→WAIT→WRITE), plus the multiplier latency.
- ALU_ctr, rd_in and instr_valid are don't-care outside IDLE.
- A back-to-back multiply arriving in WRITE is not seen until IDLE. The front end holds it because stall re-asserts combinationally in IDLE.
- wb_data and wb_addr hold their values until the next capture; only wb_en qualifies them.
- Asynchronous reset at any point, including mid-WAIT:
  - FSM returns to IDLE and all outputs drop to 0 without waiting for a clock.
  - Any in-flight multiply result is discarded.
  - Execute-stage state is cleared by its own reset.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - If the WAIT counter reaches TIMEOUT-1 with no mult_done, the FSM goes to WRITE with wb_data=32'h0 and sets mult_err=1.
  - mult_err is sticky until reset.
  - A mult_done in the same cycle as the timeout wins: normal capture, no error.
- Undefined: WAIT holds indefinitely; mult_err is tied to 0; the counter is still present and only feeds saturation.

Test Plan:
- Reset: hold reset=0 mid-WAIT → all outputs 0 immediately (no clock); FSM IDLE after release; a later mult_done is ignored.
- Signed multiply: ALU_ctr=6'h0e, rd_in=5'd9, mult_done after 32 WAIT cycles with exec_out=32'hFFFF_FFFA → doMult single pulse; stall high from issue cycle to last WAIT; wb_en one cycle, wb_addr=9, wb_data=32'hFFFF_FFFA.
- Unsigned multiply with immediate done: ALU_ctr=6'h16, mult_done=1 from issue onward, exec_out=32'h0001_0000 → done ignored in IDLE/START; capture in first WAIT cycle; wb_en exactly 3 cycles after issue.
- Non-multiply: ALU_ctr=6'h00, instr_valid=1 for 10 cycles → stall, doMult, wb_en, busy all stay 0.
- Back-to-back: second multiply (rd=5'd3) presented during WRITE of the first (rd=5'd7) → two wb_en pulses with addresses 7 then 3; exactly two doMult pulses.
- MULT_TIMEOUT_EN, TIMEOUT=8, no mult_done → wb_en after 8 WAIT cycles with wb_data=0; mult_err=1 and stays 1 through a following successful multiply.
